// File: rtl/mux_nx1_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_reg
// Description : Registered N-input, WIDTH-bit multiplexer with a valid/ready
//               output handshake. In direct mode the select input picks the
//               source. In round-robin mode an internal pointer grants the
//               next valid channel. The output slot can be refilled in the
//               same cycle that the consumer drains it, so there is no bubble.
//               Optional macro MUX_NX1_STALL_CNT_EN adds a saturating 16-bit
//               stall counter output (stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nx1_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_bus,
    input  logic [N-1:0]         in_valid,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    input  logic                 out_ready,
    output logic [N-1:0]         in_ack,
    output logic [WIDTH-1:0]     Y,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     out_sel
`ifdef MUX_NX1_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam logic [SEL_W-1:0] c_RR_RESET = SEL_W'(N - 1);

    logic [WIDTH-1:0] y_q,         y_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             w_slot_free;
    logic             w_cand_found;
    logic [SEL_W-1:0] w_cand_idx;
    logic [WIDTH-1:0] w_cand_data;
    logic             w_capture;

    // The slot can take a new word when it is empty or is being drained now.
    assign w_slot_free = !out_valid_q || out_ready;
    assign w_capture   = w_slot_free && w_cand_found;

    // Candidate search. Loops index only with constant loop variables so
    // that every select stays in range for non-power-of-2 N.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand_idx   = '0;
        w_cand_data  = '0;
        if (!mode) begin
            // Direct: an out-of-range select never matches any channel.
            for (int k = 0; k < N; k++) begin
                if ((int'(sel) == k) && in_valid[k]) begin
                    w_cand_found = 1'b1;
                    w_cand_idx   = SEL_W'(k);
                    w_cand_data  = in_bus[k*WIDTH +: WIDTH];
                end
            end
        end else begin
            // Round-robin: walk rr_ptr+1 .. rr_ptr (mod N), first valid wins.
            for (int off = 1; off <= N; off++) begin
                for (int k = 0; k < N; k++) begin
                    if (!w_cand_found && in_valid[k] &&
                        ((int'(rr_ptr_q) + off == k) ||
                         (int'(rr_ptr_q) + off == k + N))) begin
                        w_cand_found = 1'b1;
                        w_cand_idx   = SEL_W'(k);
                        w_cand_data  = in_bus[k*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // One-hot acknowledge of the channel captured this cycle; silent in reset.
    always_comb begin
        in_ack = '0;
        if (w_capture && !reset) begin
            for (int k = 0; k < N; k++) begin
                if (w_cand_idx == SEL_W'(k)) begin
                    in_ack[k] = 1'b1;
                end
            end
        end
    end

    // Next-state: capture when possible, empty the slot when nothing to take.
    always_comb begin
        y_d         = y_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_slot_free) begin
            if (w_cand_found) begin
                y_d         = w_cand_data;
                out_sel_d   = w_cand_idx;
                out_valid_d = 1'b1;
                if (mode) begin
                    rr_ptr_d = w_cand_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; rr_ptr resets to N-1 so the first search starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            rr_ptr_q    <= c_RR_RESET;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

`ifdef MUX_NX1_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles in which a held word was refused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nx1_reg
// Description : Directed self-checking bench for mux_nx1_reg (N=4 and N=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nx1_reg;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    // Main instance: WIDTH=32, N=4, SEL_W=2
    logic [127:0] in_bus;
    logic [3:0]   in_valid;
    logic [1:0]   sel;
    logic         mode;
    logic         out_ready;
    logic [3:0]   in_ack;
    logic [31:0]  Y;
    logic         out_valid;
    logic [1:0]   out_sel;

    // Second instance: WIDTH=8, N=3, SEL_W=2
    logic [23:0]  in_bus3;
    logic [2:0]   in_valid3;
    logic [1:0]   sel3;
    logic         mode3;
    logic         out_ready3;
    logic [2:0]   in_ack3;
    logic [7:0]   Y3;
    logic         out_valid3;
    logic [1:0]   out_sel3;

`ifdef MUX_NX1_STALL_CNT_EN
    logic [15:0]  stall_cnt;
    logic [15:0]  stall_cnt3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_nx1_reg #(.WIDTH(32), .N(4), .SEL_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus),
        .in_valid  (in_valid),
        .sel       (sel),
        .mode      (mode),
        .out_ready (out_ready),
        .in_ack    (in_ack),
        .Y         (Y),
        .out_valid (out_valid),
        .out_sel   (out_sel)
`ifdef MUX_NX1_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    mux_nx1_reg #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus3),
        .in_valid  (in_valid3),
        .sel       (sel3),
        .mode      (mode3),
        .out_ready (out_ready3),
        .in_ack    (in_ack3),
        .Y         (Y3),
        .out_valid (out_valid3),
        .out_sel   (out_sel3)
`ifdef MUX_NX1_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_y_dir [4];
        int exp_sel_rr[6];
        int exp_y_rr  [6];
        exp_y_dir  = '{0, 2, 4, 8};
        exp_sel_rr = '{0, 1, 3, 0, 1, 3};
        exp_y_rr   = '{0, 2, 8, 0, 2, 8};

        in_bus    = {32'd8, 32'd4, 32'd2, 32'd0};
        in_valid  = 4'b1111;
        sel       = 2'd0;
        mode      = 1'b0;
        out_ready = 1'b1;

        in_bus3    = {8'h33, 8'h22, 8'h11};
        in_valid3  = 3'b111;
        sel3       = 2'd0;
        mode3      = 1'b0;
        out_ready3 = 1'b1;

        // Reset state, with a would-be candidate present
        #12;
        check("rst_Y",      Y,         32'd0);
        check("rst_valid",  out_valid, 32'd0);
        check("rst_sel",    out_sel,   32'd0);
        check("rst_ack",    in_ack,    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Direct sweep
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check("dir_ack", in_ack, 32'(1 << s));
            tick();
            check("dir_Y",     Y,         32'(exp_y_dir[s]));
            check("dir_sel",   out_sel,   32'(s));
            check("dir_valid", out_valid, 32'd1);
        end

        // Round-robin fairness (pointer still at reset value 3)
        mode     = 1'b1;
        in_valid = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_ack", in_ack, 32'(1 << exp_sel_rr[i]));
            tick();
            check("rr_sel", out_sel, 32'(exp_sel_rr[i]));
            check("rr_Y",   Y,       32'(exp_y_rr[i]));
        end

        // Stall hold
        mode     = 1'b0;
        in_valid = 4'b1111;
        sel      = 2'd2;
        tick();
        check("st_cap_Y", Y, 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel = 2'(i);
            #1;
            check("st_ack", in_ack, 32'd0);
            tick();
            check("st_Y",     Y,         32'd4);
            check("st_valid", out_valid, 32'd1);
            check("st_sel",   out_sel,   32'd2);
        end
`ifdef MUX_NX1_STALL_CNT_EN
        check("st_cnt", stall_cnt, 32'd5);
`endif
        out_ready = 1'b1;
        sel       = 2'd3;
        #1;
        check("rel_ack", in_ack, 32'b1000);
        tick();
        check("rel_Y",   Y,       32'd8);
        check("rel_sel", out_sel, 32'd3);

        // No candidate
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        check("nc_ack", in_ack, 32'd0);
        tick();
        check("nc_valid", out_valid, 32'd0);
        check("nc_Y",     Y,         32'd8);
        check("nc_sel",   out_sel,   32'd3);

        // Round-robin capture of channel 2 (moves pointer), stall, async reset
        mode     = 1'b1;
        in_valid = 4'b0100;
        tick();
        check("ar_cap_Y", Y, 32'd4);
        out_ready = 1'b0;
        tick();
        check("ar_hold_Y", Y, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("ar_Y",     Y,         32'd0);
        check("ar_valid", out_valid, 32'd0);
        check("ar_sel",   out_sel,   32'd0);
`ifdef MUX_NX1_STALL_CNT_EN
        check("ar_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("ar_rr_ack", in_ack, 32'b0001);
        tick();
        check("ar_rr_sel",   out_sel,   32'd0);
        check("ar_rr_valid", out_valid, 32'd1);
        check("ar_rr_Y",     Y,         32'd0);
        #1;
        tick();
        check("ar_rr2_sel", out_sel, 32'd1);
        check("ar_rr2_Y",   Y,       32'd2);

        // Non-power-of-2 N=3
        sel3 = 2'd2;
        #1;
        check("n3_ack2", in_ack3, 32'b100);
        tick();
        check("n3_Y2",   Y3,       32'h33);
        check("n3_sel2", out_sel3, 32'd2);
        sel3 = 2'd3;
        #1;
        check("n3_ack3", in_ack3, 32'd0);
        tick();
        check("n3_valid3", out_valid3, 32'd0);
        check("n3_Y3",     Y3,         32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_nx1_reg.md
Name: mux_nx1_reg

Overview:
- Parametrised, registered N-input, WIDTH-bit multiplexer with valid/ready output handshake. Successor to the combinational 4x1 32-bit mux.
- Two modes:
  - Direct mode: the select input picks the source.
  - Round-robin mode: an internal pointer grants the next valid input.
- Used for datapath operand/result selection where the consumer may stall.

Parameters:
- WIDTH, 32, data width of each input and of Y.
- N, 4, number of input channels (2..16).
- SEL_W, 2, select width; must satisfy 2^SEL_W >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_bus  input  N*WIDTH  packed inputs; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- in_valid  input  N  per-channel valid.
- sel  input  SEL_W  channel select, used in direct mode.
- mode  input  1  0 = direct, 1 = round-robin.
- out_ready  input  1  consumer accepts Y this cycle.
- in_ack  output  N  one-hot, combinational: the channel captured this cycle.
- Y  output  WIDTH  registered selected data.
- out_valid  output  1  Y holds valid data.
- out_sel  output  SEL_W  index of the channel currently held in Y.

Behaviour:
- Reset (async, immediate):
  - Y=0, out_valid=0, out_sel=0, in_ack=0.
  - rr_ptr=N-1, so the first round-robin search starts at channel 0.
- Output slot free: slot_free = !out_valid || out_ready.
- Capture happens on a clk rising edge only when slot_free=1 and a candidate channel c exists.
  - Then Y <= channel c data, out_sel <= c, out_valid <= 1, in_ack[c]=1 in that cycle.
- Latency: data appears on Y one cycle after capture. Throughput is 1 per cycle while out_ready=1.
- Direct mode candidate:
  - c = sel if sel < N and in_valid[sel]=1; otherwise there is no candidate.
  - sel >= N (non-power-of-2 N) means no candidate.
- Round-robin mode candidate:
  - Search channels rr_ptr+1, rr_ptr+2, ..., wrapping modulo N, ending at rr_ptr itself.
  - The first channel with in_valid=1 wins.
  - On capture, rr_ptr <= c.
- No candidate with slot_free=1: out_valid <= 0; Y and out_sel keep their previous values.
- Stall (out_valid=1, out_ready=0):
  - Y, out_sel and out_valid hold stable.
  - in_ack=0; no capture.
  - rr_ptr unchanged.
- Simultaneous out_ready=1 and new candidate: the old word is consumed and the new word is captured at the same edge (no bubble).
- Mode change: takes effect at the next capture decision. rr_ptr is retained across direct-mode periods and not updated by direct captures.
- Wrap-around: with rr_ptr=N-1, search starts at 0. A single valid channel is granted repeatedly.
- Reset asserted mid-stall: the held word is discarded immediately; outputs go to reset values.

Optional Feature:
- Macro: MUX_NX1_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0], reset to 0.
  - Increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Never clears except on reset.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Direct sweep: WIDTH=32, N=4, channels I0=0, I1=2, I2=4, I3=8, all in_valid=1, out_ready=1, mode=0, sel stepping 0,1,2,3 every cycle -> one cycle later Y = 0,2,4,8 and out_sel = 0,1,2,3; in_ack = 0001,0010,0100,1000 in the sel cycles.
- Round-robin fairness: mode=1, in_valid=1011, out_ready=1 -> out_sel sequence 0,1,3,0,1,3; Y = 0,2,8,0,2,8.
- Stall hold: capture I2=4, then out_ready=0 for 5 cycles with sel changing -> Y=4, out_valid=1, out_sel=2 stable, in_ack=0. Release -> next word appears the following cycle. With MUX_NX1_STALL_CNT_EN defined, stall_cnt=5.
- No candidate: mode=0, sel=1, in_valid[1]=0, out_ready=1 -> out_valid=0 next cycle, Y keeps its last value.
- Async reset: assert reset between edges during a stall -> Y=0, out_valid=0, out_sel=0 immediately. After release, round-robin with all valid grants channel 0 first.
- Non-power-of-2: N=3, SEL_W=2, sel=3, mode=0 -> out_valid=0, in_ack=000.
